// File: rtl/minicpu_pkg.sv
// rtl/minicpu_pkg.sv - shared widths, load-bit indices and types for the minicpu datapath
package minicpu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_PC_WIDTH   = 4;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  typedef logic [3:0] load_t;

endpackage

// File: rtl/alu_adder.sv
// rtl/alu_adder.sv - combinational WIDTH-bit adder with carry out of the MSB
module alu_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/register_unit.sv
// rtl/register_unit.sv - A/B/OUT/PC registers and carry flag written from sel_data + imm
module register_unit
  import minicpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PC_WIDTH   = DEFAULT_PC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] sel_data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  load_t                 load,
  output logic [DATA_WIDTH-1:0] reg_a,
  output logic [DATA_WIDTH-1:0] reg_b,
  output logic [DATA_WIDTH-1:0] reg_out,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  carry
);

  logic [DATA_WIDTH-1:0] sum;
  logic                  cout;

  logic [DATA_WIDTH-1:0] reg_a_d, reg_a_q;
  logic [DATA_WIDTH-1:0] reg_b_d, reg_b_q;
  logic [DATA_WIDTH-1:0] reg_out_d, reg_out_q;
  logic [PC_WIDTH-1:0]   pc_d, pc_q;
  logic                  carry_d, carry_q;

  alu_adder #(.WIDTH(DATA_WIDTH)) u_adder (
    .a    (sel_data),
    .b    (imm),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    reg_out_d = reg_out_q;
    pc_d      = pc_q;
    carry_d   = carry_q;
    if (en) begin
      if (load[LD_A])   reg_a_d   = sum;
      if (load[LD_B])   reg_b_d   = sum;
      if (load[LD_OUT]) reg_out_d = sum;
      // A jump replaces the increment; the increment wraps naturally at PC_WIDTH bits.
      if (load[LD_PC]) pc_d = sum[PC_WIDTH-1:0];
      else             pc_d = pc_q + PC_WIDTH'(1);
      carry_d = cout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      reg_out_q <= '0;
      pc_q      <= '0;
      carry_q   <= 1'b0;
    end else begin
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      reg_out_q <= reg_out_d;
      pc_q      <= pc_d;
      carry_q   <= carry_d;
    end
  end

  assign reg_a   = reg_a_q;
  assign reg_b   = reg_b_q;
  assign reg_out = reg_out_q;
  assign pc      = pc_q;
  assign carry   = carry_q;

endmodule

// File: doc/register_unit.md
Name: register_unit

Overview:
- Datapath stage directly downstream of the ALU-source data selector in the minicpu 4-bit core.
- Adds the selector output `sel_data` to the instruction immediate and writes the sum back to one or more of A, B, OUT or PC.
- Maintains the PC (increment or jump) and the carry flag used for conditional jumps.
- Its A and B outputs return to the selector as sources c0 and c1, closing the datapath loop.

Parameters:
- DATA_WIDTH, 4, width of A, B, OUT, the immediate, `sel_data` and the adder.
- PC_WIDTH, 4, width of the program counter. Must be ≤ DATA_WIDTH; PC loads take the low PC_WIDTH bits of the sum.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  instruction-execute enable; when low, all state holds (single-step / halt).
- sel_data  input  DATA_WIDTH  ALU source operand from the data selector.
- imm  input  DATA_WIDTH  immediate field of the current instruction.
- load  input  4  one-hot-or-more write enables: bit0=A, bit1=B, bit2=OUT, bit3=PC.
- reg_a  output  DATA_WIDTH  register A; feeds selector c0.
- reg_b  output  DATA_WIDTH  register B; feeds selector c1.
- reg_out  output  DATA_WIDTH  output-port register.
- pc  output  PC_WIDTH  program counter (ROM address).
- carry  output  1  carry flag from the last executed instruction.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high on port reset. Reset has priority over en and load.
- Reset values: reg_a=0, reg_b=0, reg_out=0, pc=0, carry=0.
- Adder (combinational): {cout, sum} = sel_data + imm, computed at DATA_WIDTH+1 bits. Overflow wraps; cout is the carry out of the MSB.
- Execute cycle (rising edge with en=1, reset=0):
  - Each register whose load bit is 1 takes `sum` (PC takes sum[PC_WIDTH-1:0]).
  - Registers with load bit 0 hold their value.
  - If load[3]=0, pc <= pc+1, wrapping from 2^PC_WIDTH-1 to 0.
  - carry <= cout on every execute cycle, regardless of load.
- Latency: all outputs update one cycle after the execute edge. No combinational path from any input to any output.
- en=0: every register, pc and carry hold; load, sel_data and imm are ignored.
- load=0: no-op (NOP-like); pc still increments and carry still updates.
- Multiple load bits set: legal; every selected register takes the same sum in the same cycle.
- Jump: load[3]=1 overrides the increment. A jump to the current pc value is legal and produces a tight loop.
- Conditional jump: decided outside this block by gating load[3] with carry. The carry seen by the decoder is the registered value from the previous instruction.
- Reset asserted mid-stream (any en/load): next edge forces the reset values; the first execute after reset deassertion fetches from pc=0.
- The unit is a pure state-holding stage with no handshake beyond en.

Decomposition:
- Package minicpu_pkg holds:
  - DATA_WIDTH/PC_WIDTH defaults.
  - localparam load-bit indices LD_A=0, LD_B=1, LD_OUT=2, LD_PC=3.
  - typedef load_t (logic [3:0]).
- One sub-module is natural: alu_adder, a combinational DATA_WIDTH adder producing sum and cout. It is reused by the unit and is testable in isolation.
- Registers and the PC logic stay in register_unit.

Test Plan:
- Reset: drive reset=1 for 2 cycles with en=1, load=4'b1111, sel_data=4'h7, imm=4'h3 -> all outputs 0 after the reset edge; pc does not increment.
- ADD A,imm: reg_a=5, sel_data=5, imm=4'hC, load=4'b0001, en=1 -> next cycle reg_a=1, carry=1, pc incremented by 1, reg_b/reg_out unchanged.
- Multi-load plus no-carry: sel_data=2, imm=3, load=4'b0110 -> reg_b=5, reg_out=5, carry=0; following cycle with load=0, sel_data=0, imm=0 -> carry=0, pc+1, all registers hold.
- PC jump and wrap:
  - Let pc count from 14 with load=0 -> pc 15 then 0.
  - Then load=4'b1000, sel_data=0, imm=9 -> pc=9 next cycle, no increment.
- Hold: en=0 for 5 cycles with load=4'b1111 and varying data -> all outputs constant; en=1 resumes with normal update on the next edge.
- Reset mid-stream: assert reset on the same edge as load=4'b1000, imm=4'hA -> pc=0, carry=0, not 10; the next execute cycle gives pc=1.
